pgm_ddram_bridge: RTL

// Responder for the core's DDRAM request bus (rd/we/addr/din/be -> dout/busy/dout_ready) that the 50 MHz arbiter and ROM loader drive.

---
 rtl/pgm_ddram_bridge.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pgm_ddram_bridge.sv
// pgm_ddram_bridge: responder for the core's DDRAM request bus. Turns rd/we
// requests into single-beat Avalon-MM transactions, buffers loader writes in
// a small FIFO and keeps a one-line read cache for repeated word fetches.
module pgm_ddram_bridge #(
    parameter int WFIFO_DEPTH = 4,
    parameter bit CACHE_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        ddram_rd,
    input  logic        ddram_we,
    input  logic [28:0] ddram_addr,
    input  logic [63:0] ddram_din,
    input  logic [7:0]  ddram_be,
    output logic [63:0] ddram_dout,
    output logic        ddram_busy,
    output logic        ddram_dout_ready,

    output logic [28:0] avl_address,
    output logic [7:0]  avl_burstcount,
    output logic        avl_read,
    output logic        avl_write,
    output logic [63:0] avl_writedata,
    output logic [7:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [63:0] avl_readdata,
    input  logic        avl_readdatavalid,

    output logic        err_overflow
);

    localparam int AW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam int EW = 29 + 64 + 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [EW-1:0] fifoMem_q [WFIFO_DEPTH];
    logic [28:0]   rdAddr_q, rdAddr_d;
    logic [63:0]   dout_q, dout_d;
    logic          doutReady_q, doutReady_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          cacheValid_q, cacheValid_d;
    logic [28:0]   cacheTag_q, cacheTag_d;

    logic          fifoEmpty;
    logic          fifoFull;
    logic          fullNext;
    logic          doPush;
    logic          doPop;
    logic          cacheHit;
    logic [EW-1:0] fifoHead;

    // The pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush    = ddram_we && !fifoFull;
    assign doPop     = (state_q == WR_ISSUE) && !avl_waitrequest;
    assign fifoHead  = fifoMem_q[rdPtr_q[AW-1:0]];

    // The read data register doubles as the cache line: it only changes on a
    // miss fill (which also sets the tag) or a hit (which reloads the same value).
    assign cacheHit = CACHE_EN && cacheValid_q && (ddram_addr == cacheTag_q);

    // Next-state logic for the FSM, FIFO pointers, cache and status flags.
    always_comb begin
        state_d      = state_q;
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        rdAddr_d     = rdAddr_q;
        dout_d       = dout_q;
        doutReady_d  = 1'b0;
        overflow_d   = overflow_q;
        cacheValid_d = cacheValid_q;
        cacheTag_d   = cacheTag_q;
        busy_d       = 1'b0;
        fullNext     = 1'b0;

        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (ddram_we && fifoFull) begin
            overflow_d = 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                // A write arriving this cycle counts as pending so it drains before any read.
                if (!fifoEmpty || doPush) begin
                    state_d = WR_ISSUE;
                end else if (ddram_rd) begin
                    if (cacheHit) begin
                        state_d     = RD_DONE;
                        doutReady_d = 1'b1;
                    end else begin
                        state_d  = RD_ISSUE;
                        rdAddr_d = ddram_addr;
                    end
                end
            end
            WR_ISSUE: begin
                if (doPop && (wrPtr_d == rdPtr_d)) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!avl_waitrequest) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avl_readdatavalid) begin
                    dout_d       = avl_readdata;
                    cacheTag_d   = rdAddr_q;
                    cacheValid_d = CACHE_EN;
                    doutReady_d  = 1'b1;
                    state_d      = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A write to the cached word makes the line stale, even if it was filled this cycle.
        if (doPush && (ddram_addr == cacheTag_d)) begin
            cacheValid_d = 1'b0;
        end

        fullNext = (wrPtr_d[AW] != rdPtr_d[AW]) && (wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]);
        busy_d   = fullNext || (state_d == RD_ISSUE) || (state_d == RD_WAIT) || (state_d == RD_DONE);
    end

    // State and control registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            rdAddr_q     <= '0;
            dout_q       <= '0;
            doutReady_q  <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            cacheValid_q <= 1'b0;
            cacheTag_q   <= '0;
        end else begin
            state_q      <= state_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            rdAddr_q     <= rdAddr_d;
            dout_q       <= dout_d;
            doutReady_q  <= doutReady_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            cacheValid_q <= cacheValid_d;
            cacheTag_q   <= cacheTag_d;
        end
    end

    // FIFO storage needs no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem_q[wrPtr_q[AW-1:0]] <= {ddram_addr, ddram_din, ddram_be};
        end
    end

    // Avalon command outputs follow the state; the FIFO head is stable until popped.
    always_comb begin
        avl_read       = 1'b0;
        avl_write      = 1'b0;
        avl_address    = '0;
        avl_writedata  = '0;
        avl_byteenable = '0;
        case (state_q)
            WR_ISSUE: begin
                avl_write = 1'b1;
                {avl_address, avl_writedata, avl_byteenable} = fifoHead;
            end
            RD_ISSUE: begin
                avl_read    = 1'b1;
                avl_address = rdAddr_q;
            end
            default: begin
            end
        endcase
    end

    assign avl_burstcount   = 8'd1;
    assign ddram_dout       = dout_q;
    assign ddram_dout_ready = doutReady_q;
    assign ddram_busy       = busy_q;
    assign err_overflow     = overflow_q;

endmodule
